// File: rtl/m_control_fsm_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes,
// R-type functs and ALU operation codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LW_WB    = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXE    = 4'd6,
    S_R_WB     = 4'd7,
    S_BEQ      = 4'd8,
    S_J        = 4'd9,
    S_I_EXE    = 4'd10,
    S_I_WB     = 4'd11,
    S_BNE      = 4'd12
  } state_t;

  // Which flavour of ALU operation the current state asks for.
  typedef enum logic [1:0] {
    CLS_ADD = 2'd0,
    CLS_SUB = 2'd1,
    CLS_R   = 2'd2,
    CLS_I   = 2'd3
  } alu_cls_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/m_control_fsm_if.sv
// Control/datapath bundle: master is the control FSM, slave is the
// datapath plus memory bus that consumes the controls.
interface m_control_fsm_if;
  logic [31:0] Inst;
  logic        zero;
  logic        MIO_ready;
  logic        IorD;
  logic        IRWrite;
  logic [1:0]  RegDst;
  logic        RegWrite;
  logic [1:0]  MemtoReg;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSource;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        Branch;
  logic [2:0]  ALU_operation;
  logic        mem_w;
  logic [3:0]  state;
  logic        illegal;

  modport master (
    input  Inst, zero, MIO_ready,
    output IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB,
           PCSource, PCWrite, PCWriteCond, Branch, ALU_operation, mem_w,
           state, illegal
  );

  modport slave (
    output Inst, zero, MIO_ready,
    input  IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB,
           PCSource, PCWrite, PCWriteCond, Branch, ALU_operation, mem_w,
           state, illegal
  );
endinterface

// File: rtl/m_control_fsm_alu_decode.sv
// Maps (state class, opcode, funct) to an ALU op; funct_ok flags a
// supported R-type funct so ID can reuse it for the illegal check.
module alu_decode
  import ctrl_pkg::*;
(
  input  alu_cls_t   cls,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       funct_ok
);

  logic [2:0] r_op;

  always_comb begin
    r_op     = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      FN_ADD:  r_op = ALU_ADD;
      FN_SUB:  r_op = ALU_SUB;
      FN_AND:  r_op = ALU_AND;
      FN_OR:   r_op = ALU_OR;
      FN_XOR:  r_op = ALU_XOR;
      FN_NOR:  r_op = ALU_NOR;
      FN_SLT:  r_op = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    alu_op = ALU_ADD;
    case (cls)
      CLS_SUB: alu_op = ALU_SUB;
      CLS_R:   alu_op = r_op;
      CLS_I:   alu_op = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/m_control_fsm.sv
// Moore sequencer for the multi-cycle MIPS-subset datapath. Mealy paths:
// BNE PCWrite (follows zero) and the ID illegal pulse (follows Inst).
//
// state    | meaning
// IF       | fetch, PC+4; wait for MIO_ready
// ID       | decode, branch target into ALUOut
// MEM_ADDR | base + offset for lw/sw
// MEM_RD   | read data memory; wait for MIO_ready
// LW_WB    | memory data to rt
// MEM_WR   | write data memory; wait for MIO_ready
// R_EXE    | R-type ALU op from funct
// R_WB     | ALU result to rd
// BEQ      | compare, conditional PC write
// J        | jump target to PC
// I_EXE    | addi/slti with sign-extended immediate
// I_WB     | ALU result to rt
// BNE      | compare, PC write when not zero
module m_control_fsm
  import ctrl_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  m_control_fsm_if.master bus
);

  state_t     state_q, state_nxt;
  alu_cls_t   alu_cls;
  logic [5:0] opcode, funct;
  logic       funct_ok;
  logic       unused_inst;

  assign opcode      = bus.Inst[31:26];
  assign funct       = bus.Inst[5:0];
  assign unused_inst = ^bus.Inst[25:6];
  assign bus.state   = state_q;

  alu_decode u_alu_decode (
    .cls      (alu_cls),
    .opcode   (opcode),
    .funct    (funct),
    .alu_op   (bus.ALU_operation),
    .funct_ok (funct_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IF;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt       = state_q;
    alu_cls         = CLS_ADD;
    bus.IorD        = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegDst      = 2'b00;
    bus.RegWrite    = 1'b0;
    bus.MemtoReg    = 2'b00;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.PCSource    = 2'b00;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.Branch      = 1'b0;
    bus.mem_w       = 1'b0;
    bus.illegal     = 1'b0;
    case (state_q)
      S_IF: begin
        bus.IRWrite = 1'b1;
        bus.PCWrite = 1'b1;
        bus.ALUSrcB = 2'b01;
        if (bus.MIO_ready) state_nxt = S_ID;
      end
      S_ID: begin
        bus.ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW:     state_nxt = S_MEM_ADDR;
          OP_BEQ:           state_nxt = S_BEQ;
          OP_BNE:           state_nxt = S_BNE;
          OP_J:             state_nxt = S_J;
          OP_ADDI, OP_SLTI: state_nxt = S_I_EXE;
          OP_R: begin
            state_nxt   = funct_ok ? S_R_EXE : S_IF;
            bus.illegal = ~funct_ok;
          end
          default: begin
            state_nxt   = S_IF;
            bus.illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_nxt   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        bus.IorD = 1'b1;
        if (bus.MIO_ready) state_nxt = S_LW_WB;
      end
      S_LW_WB: begin
        bus.MemtoReg = 2'b01;
        bus.RegWrite = 1'b1;
        state_nxt    = S_IF;
      end
      S_MEM_WR: begin
        bus.IorD  = 1'b1;
        bus.mem_w = 1'b1;
        if (bus.MIO_ready) state_nxt = S_IF;
      end
      S_R_EXE: begin
        bus.ALUSrcA = 1'b1;
        alu_cls     = CLS_R;
        state_nxt   = S_R_WB;
      end
      S_R_WB: begin
        bus.RegDst   = 2'b01;
        bus.RegWrite = 1'b1;
        state_nxt    = S_IF;
      end
      S_BEQ: begin
        bus.ALUSrcA     = 1'b1;
        alu_cls         = CLS_SUB;
        bus.PCWriteCond = 1'b1;
        bus.Branch      = 1'b1;
        bus.PCSource    = 2'b01;
        state_nxt       = S_IF;
      end
      S_BNE: begin
        bus.ALUSrcA  = 1'b1;
        alu_cls      = CLS_SUB;
        bus.PCSource = 2'b01;
        bus.PCWrite  = ~bus.zero;
        state_nxt    = S_IF;
      end
      S_J: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
        state_nxt    = S_IF;
      end
      S_I_EXE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        alu_cls     = CLS_I;
        state_nxt   = S_I_WB;
      end
      S_I_WB: begin
        bus.RegWrite = 1'b1;
        state_nxt    = S_IF;
      end
      default: state_nxt = S_IF;
    endcase
  end

endmodule

// File: tb/tb_m_control_fsm.sv
// Directed per-cycle vectors for m_control_fsm plus hand sequences for the
// BNE zero path and asynchronous reset during a memory write.
module tb_m_control_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  m_control_fsm_if bus ();

  m_control_fsm u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // {IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB,
  //  PCSource, PCWrite, PCWriteCond, Branch, ALU_operation, mem_w, illegal}
  localparam logic [19:0] E_IF    = {1'b0,1'b1,2'b00,1'b0,2'b00,1'b0,2'b01,2'b00,1'b1,1'b0,1'b0,3'b010,1'b0,1'b0};
  localparam logic [19:0] E_ID    = {1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,2'b11,2'b00,1'b0,1'b0,1'b0,3'b010,1'b0,1'b0};
  localparam logic [19:0] E_IDILL = {1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,2'b11,2'b00,1'b0,1'b0,1'b0,3'b010,1'b0,1'b1};
  localparam logic [19:0] E_MADDR = {1'b0,1'b0,2'b00,1'b0,2'b00,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,3'b010,1'b0,1'b0};
  localparam logic [19:0] E_MRD   = {1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,3'b010,1'b0,1'b0};
  localparam logic [19:0] E_LWWB  = {1'b0,1'b0,2'b00,1'b1,2'b01,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,3'b010,1'b0,1'b0};
  localparam logic [19:0] E_MWR   = {1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,3'b010,1'b1,1'b0};
  localparam logic [19:0] E_RWB   = {1'b0,1'b0,2'b01,1'b1,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,3'b010,1'b0,1'b0};
  localparam logic [19:0] E_BEQ   = {1'b0,1'b0,2'b00,1'b0,2'b00,1'b1,2'b00,2'b01,1'b0,1'b1,1'b1,3'b110,1'b0,1'b0};
  localparam logic [19:0] E_J     = {1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,2'b10,1'b1,1'b0,1'b0,3'b010,1'b0,1'b0};
  localparam logic [19:0] E_IWB   = {1'b0,1'b0,2'b00,1'b1,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,3'b010,1'b0,1'b0};

  function automatic logic [19:0] e_rexe(input logic [2:0] op);
    return {1'b0,1'b0,2'b00,1'b0,2'b00,1'b1,2'b00,2'b00,1'b0,1'b0,1'b0,op,1'b0,1'b0};
  endfunction
  function automatic logic [19:0] e_iexe(input logic [2:0] op);
    return {1'b0,1'b0,2'b00,1'b0,2'b00,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,op,1'b0,1'b0};
  endfunction
  function automatic logic [19:0] e_bne(input logic pcw);
    return {1'b0,1'b0,2'b00,1'b0,2'b00,1'b1,2'b00,2'b01,pcw,1'b0,1'b0,3'b110,1'b0,1'b0};
  endfunction

  localparam logic [31:0] I_ADD  = 32'h012A4020;
  localparam logic [31:0] I_SUB  = 32'h012A4022;
  localparam logic [31:0] I_NOR  = 32'h012A4027;
  localparam logic [31:0] I_SLT  = 32'h012A402A;
  localparam logic [31:0] I_LW   = 32'h8D090004;
  localparam logic [31:0] I_SW   = 32'hAD090008;
  localparam logic [31:0] I_BEQ  = 32'h11090003;
  localparam logic [31:0] I_BNE  = 32'h15090003;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_ADDI = 32'h21090005;
  localparam logic [31:0] I_SLTI = 32'h29090005;
  localparam logic [31:0] I_BADOP = 32'hFC000000;
  localparam logic [31:0] I_BADFN = 32'h012A403F;

  typedef struct {
    logic [31:0] inst;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic [19:0] ctl;
  } vec_t;

  vec_t vt[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [19:0] ctl_act;
  assign ctl_act = {bus.IorD, bus.IRWrite, bus.RegDst, bus.RegWrite, bus.MemtoReg,
                    bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.PCWrite,
                    bus.PCWriteCond, bus.Branch, bus.ALU_operation, bus.mem_w,
                    bus.illegal};

  task automatic v(input logic [31:0] i, input logic z, input logic r,
                   input logic [3:0] s, input logic [19:0] c);
    vec_t e;
    e.inst = i; e.zero = z; e.rdy = r; e.st = s; e.ctl = c;
    vt.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [3:0] s, input logic [19:0] c);
    n_vec++;
    if (bus.state !== s || ctl_act !== c) begin
      n_err++;
      $display("FAIL %s: state=%0d ctl=%05h, required state=%0d ctl=%05h",
               nm, bus.state, ctl_act, s, c);
    end
  endtask

  initial begin
    // add: 0,1,6,7
    v(I_ADD, 0, 1, 0, E_IF);  v(I_ADD, 0, 1, 1, E_ID);
    v(I_ADD, 0, 1, 6, e_rexe(3'b010)); v(I_ADD, 0, 1, 7, E_RWB);
    // lw with two wait cycles in MEM_RD
    v(I_LW, 0, 1, 0, E_IF);  v(I_LW, 0, 1, 1, E_ID);  v(I_LW, 0, 1, 2, E_MADDR);
    v(I_LW, 0, 0, 3, E_MRD); v(I_LW, 0, 0, 3, E_MRD); v(I_LW, 0, 1, 3, E_MRD);
    v(I_LW, 0, 1, 4, E_LWWB);
    // sw, then sw with one MEM_WR wait
    v(I_SW, 0, 1, 0, E_IF);  v(I_SW, 0, 1, 1, E_ID);  v(I_SW, 0, 1, 2, E_MADDR);
    v(I_SW, 0, 1, 5, E_MWR);
    v(I_SW, 0, 1, 0, E_IF);  v(I_SW, 0, 1, 1, E_ID);  v(I_SW, 0, 1, 2, E_MADDR);
    v(I_SW, 0, 0, 5, E_MWR); v(I_SW, 0, 1, 5, E_MWR);
    // other R-type functs, with fetch waits on sub
    v(I_SUB, 0, 0, 0, E_IF); v(I_SUB, 0, 0, 0, E_IF); v(I_SUB, 0, 1, 0, E_IF);
    v(I_SUB, 0, 1, 1, E_ID); v(I_SUB, 0, 1, 6, e_rexe(3'b110)); v(I_SUB, 0, 1, 7, E_RWB);
    v(I_NOR, 0, 1, 0, E_IF); v(I_NOR, 0, 1, 1, E_ID); v(I_NOR, 0, 1, 6, e_rexe(3'b100)); v(I_NOR, 0, 1, 7, E_RWB);
    v(I_SLT, 0, 1, 0, E_IF); v(I_SLT, 0, 1, 1, E_ID); v(I_SLT, 0, 1, 6, e_rexe(3'b111)); v(I_SLT, 0, 1, 7, E_RWB);
    // branches and jump
    v(I_BEQ, 1, 1, 0, E_IF); v(I_BEQ, 1, 1, 1, E_ID); v(I_BEQ, 1, 1, 8, E_BEQ);
    v(I_BNE, 0, 1, 0, E_IF); v(I_BNE, 0, 1, 1, E_ID); v(I_BNE, 0, 1, 12, e_bne(1'b1));
    v(I_BNE, 1, 1, 0, E_IF); v(I_BNE, 1, 1, 1, E_ID); v(I_BNE, 1, 1, 12, e_bne(1'b0));
    v(I_J, 0, 1, 0, E_IF);   v(I_J, 0, 1, 1, E_ID);   v(I_J, 0, 1, 9, E_J);
    // immediates
    v(I_ADDI, 0, 1, 0, E_IF); v(I_ADDI, 0, 1, 1, E_ID); v(I_ADDI, 0, 1, 10, e_iexe(3'b010)); v(I_ADDI, 0, 1, 11, E_IWB);
    v(I_SLTI, 0, 1, 0, E_IF); v(I_SLTI, 0, 1, 1, E_ID); v(I_SLTI, 0, 1, 10, e_iexe(3'b111)); v(I_SLTI, 0, 1, 11, E_IWB);
    // unsupported opcode and funct: pulse in ID, back to IF
    v(I_BADOP, 0, 1, 0, E_IF); v(I_BADOP, 0, 1, 1, E_IDILL);
    v(I_BADFN, 0, 1, 0, E_IF); v(I_BADFN, 0, 1, 1, E_IDILL);
    v(I_ADD, 0, 0, 0, E_IF);

    bus.Inst = I_BADOP; bus.zero = 1'b0; bus.MIO_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", 4'd0, E_IF);

    bus.MIO_ready = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < vt.size(); k++) begin
      bus.Inst = vt[k].inst; bus.zero = vt[k].zero; bus.MIO_ready = vt[k].rdy;
      #1;
      chk($sformatf("vec%0d", k), vt[k].st, vt[k].ctl);
      @(negedge clk);
    end

    // BNE PCWrite tracks zero within the cycle
    bus.Inst = I_BNE; bus.zero = 1'b0; bus.MIO_ready = 1'b1;
    #1 chk("bne_if", 4'd0, E_IF);
    @(negedge clk); #1 chk("bne_id", 4'd1, E_ID);
    @(negedge clk); #1 chk("bne_z0", 4'd12, e_bne(1'b1));
    bus.zero = 1'b1;
    #1 chk("bne_z1", 4'd12, e_bne(1'b0));
    bus.zero = 1'b0;
    #1 chk("bne_z0_again", 4'd12, e_bne(1'b1));

    // asynchronous reset in the middle of a held MEM_WR
    @(negedge clk);
    bus.Inst = I_SW; bus.MIO_ready = 1'b1;
    #1 chk("swr_if", 4'd0, E_IF);
    @(negedge clk); #1 chk("swr_id", 4'd1, E_ID);
    @(negedge clk); #1 chk("swr_addr", 4'd2, E_MADDR);
    bus.MIO_ready = 1'b0;
    @(negedge clk); #1 chk("swr_wait", 4'd5, E_MWR);
    #2 rst_n = 1'b0;
    #1 chk("swr_async_rst", 4'd0, E_IF);
    @(negedge clk); #1 chk("swr_rst_held", 4'd0, E_IF);
    bus.MIO_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk); #1 chk("post_rst_id", 4'd1, E_ID);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
